axi_lite_xbar_conn: RTL and testbench
=====================================

AXI_LITE_XBAR_CONN -- requirements
Module: axi_lite_xbar_conn

Interface
REQ-001 SHALL have parameter NoSlvPorts, 2, number of slave ports; valid range 1..16.
REQ-002 SHALL have parameter NoMstPorts, 2, number of master ports; valid range 1..16.
REQ-003 SHALL have parameter NoAddrRules, 2, number of address map rules.
REQ-004 SHALL have parameter AddrWidth, 32, AXI address width.
REQ-005 SHALL have parameter DataWidth, 32, AXI data width (32 or 64).
REQ-006 SHALL have parameter Connectivity, all ones, NoSlvPorts x NoMstPorts bit matrix; bit [i][j] set means slave port i may reach master port j.
REQ-007 SHALL have type parameters aw_chan_t, w_chan_t, b_chan_t, ar_chan_t, r_chan_t, req_t, resp_t (AXI4-Lite) and rule_t ({idx, start_addr, end_addr}).
REQ-008 SHALL have port clk_i, input, 1, clock; all logic is on the rising edge.
REQ-009 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-010 SHALL have port slv_ports_req_i, input, [NoSlvPorts] req_t, slave-port requests.
REQ-011 SHALL have port slv_ports_resp_o, output, [NoSlvPorts] resp_t, slave-port responses.
REQ-012 SHALL have port mst_ports_req_o, output, [NoMstPorts] req_t, master-port requests.
REQ-013 SHALL have port mst_ports_resp_i, input, [NoMstPorts] resp_t, master-port responses.
REQ-014 SHALL have port addr_map_i, input, [NoAddrRules] rule_t, address map.
REQ-015 SHALL have port en_default_mst_port_i, input, [NoSlvPorts] 1, per-slave-port default-route enable.
REQ-016 SHALL have port default_mst_port_i, input, [NoSlvPorts] clog2(NoMstPorts), default master port index.

Function
REQ-017 Each slave port SHALL run an independent write FSM with states W_IDLE, W_REQ, W_DATA, W_RESP, W_ERR_DATA and W_ERR_RESP.
REQ-018 Each slave port SHALL run an independent read FSM with states R_IDLE, R_REQ, R_RESP and R_ERR.
REQ-019 Each slave port SHALL allow at most one outstanding write and one outstanding read.
REQ-020 aw_ready and ar_ready SHALL be 1 only in W_IDLE and R_IDLE; on handshake the address is registered and decoded.
REQ-021 Address decode SHALL use half-open ranges [start_addr, end_addr); if several rules match, the lowest rule index wins.
REQ-022 Decode with no match SHALL route to default_mst_port_i[i] when en_default_mst_port_i[i] is set; otherwise it SHALL be a decode error.
REQ-023 A decoded target j with Connectivity[i][j]=0 SHALL be a decode error.
REQ-024 On a decode error, the write FSM SHALL go to W_ERR_DATA and the read FSM to R_ERR; otherwise they SHALL go to W_REQ and R_REQ.
REQ-025 Each master port SHALL hold independent write and read locks; each lock is owned by at most one slave port.
REQ-026 When a lock is free, a round-robin arbiter SHALL grant among slave ports in REQ targeting that port; the grant and owner are registered and the lock is set.
REQ-027 After each grant the round-robin pointer SHALL become (grant+1) mod NoSlvPorts.
REQ-028 The master aw_valid/ar_valid SHALL be driven from the registered owner request starting the cycle after the grant and held until handshake; earliest master valid is 2 cycles after the slave Ax handshake.
REQ-029 W_DATA SHALL pass W combinationally between the owner slave port and master port j; on the W handshake the FSM SHALL go to W_RESP.
REQ-030 W_RESP and R_RESP SHALL pass B and R combinationally from master j to the owner; on handshake the FSM returns to IDLE and lock j is released the same cycle.
REQ-031 A released lock SHALL be grantable in the next cycle.
REQ-032 W_ERR_DATA SHALL assert w_ready=1 and absorb one W beat, then go to W_ERR_RESP.
REQ-033 W_ERR_RESP and R_ERR SHALL assert b_valid / r_valid with resp=2'b11 (DECERR) and r.data=0 until handshake, then return to IDLE.
REQ-034 A master port SHALL never see valid from a non-owner, and every unowned master port SHALL drive all valid and ready signals to 0.
REQ-035 Simultaneous release and new request on the same master port SHALL grant in the cycle after release.
REQ-036 Write and read paths SHALL never block each other.

Reset
REQ-037 While rst_i=1, all FSMs SHALL be IDLE, all locks clear, all pointers 0, and every valid and ready output 0.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction with no response issued.
REQ-039 After reset deassertion, aw_ready and ar_ready SHALL be 1 on the next cycle.

Verification
REQ-040 Map {0:[0x0,0x1000), 1:[0x1000,0x2000)}; slave 0 writes 0x1004 data 0xA5 -> master 1 sees AW 0x1004 at T+2, then W, then B OKAY returned to slave 0.
REQ-041 Slaves 0 and 1 both read 0x0010 in the same cycle -> master 0 serves slave 0 first, then slave 1; the next contention is won by slave 1.
REQ-042 Read 0x5000 with default disabled -> R DECERR, data 0, and no master valid.
REQ-043 Connectivity[1][0]=0 and slave 1 writes 0x0 -> W absorbed, B DECERR, master 0 idle.
REQ-044 Concurrent write and read from slave 0 to master 1 -> both complete with no serialisation stall.
REQ-045 rst_i pulsed while in W_DATA -> all outputs 0, then normal operation on the following transaction.

Source files
------------

// File: rtl/axi_lite_xbar_conn.sv
// AXI4-Lite crossbar connection core: per-slave-port single-outstanding write/read FSMs,
// per-master-port write/read locks with round-robin grant, and DECERR handling for unroutable accesses.
package axi_lite_xbar_conn_pkg;
  typedef struct packed {logic [31:0] addr; logic [2:0] prot;} aw_chan_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb;} w_chan_t;
  typedef struct packed {logic [1:0] resp;} b_chan_t;
  typedef struct packed {logic [31:0] addr; logic [2:0] prot;} ar_chan_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp;} r_chan_t;
  typedef struct packed {
    aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
    ar_chan_t ar; logic ar_valid; logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready; logic w_ready; b_chan_t b; logic b_valid;
    logic ar_ready; r_chan_t r; logic r_valid;
  } resp_t;
  typedef struct packed {logic [31:0] idx; logic [31:0] start_addr; logic [31:0] end_addr;} rule_t;
endpackage

module axi_lite_xbar_conn #(
  parameter int unsigned NoSlvPorts  = 2,
  parameter int unsigned NoMstPorts  = 2,
  parameter int unsigned NoAddrRules = 2,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter bit [NoSlvPorts-1:0][NoMstPorts-1:0] Connectivity = '1,
  parameter type aw_chan_t = axi_lite_xbar_conn_pkg::aw_chan_t,
  parameter type w_chan_t  = axi_lite_xbar_conn_pkg::w_chan_t,
  parameter type b_chan_t  = axi_lite_xbar_conn_pkg::b_chan_t,
  parameter type ar_chan_t = axi_lite_xbar_conn_pkg::ar_chan_t,
  parameter type r_chan_t  = axi_lite_xbar_conn_pkg::r_chan_t,
  parameter type req_t     = axi_lite_xbar_conn_pkg::req_t,
  parameter type resp_t    = axi_lite_xbar_conn_pkg::resp_t,
  parameter type rule_t    = axi_lite_xbar_conn_pkg::rule_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  req_t  [NoSlvPorts-1:0]  slv_ports_req_i,
  output resp_t [NoSlvPorts-1:0]  slv_ports_resp_o,
  output req_t  [NoMstPorts-1:0]  mst_ports_req_o,
  input  resp_t [NoMstPorts-1:0]  mst_ports_resp_i,
  input  rule_t [NoAddrRules-1:0] addr_map_i,
  input  logic  [NoSlvPorts-1:0]  en_default_mst_port_i,
  input  logic  [NoSlvPorts-1:0][(NoMstPorts > 1 ? $clog2(NoMstPorts) : 1)-1:0] default_mst_port_i
);
  localparam int unsigned MstIdxW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;
  localparam int unsigned SlvIdxW = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1;

  localparam logic [2:0] W_IDLE = 3'd0, W_REQ = 3'd1, W_DATA = 3'd2, W_RESP = 3'd3,
                         W_ERR_DATA = 3'd4, W_ERR_RESP = 3'd5;
  localparam logic [1:0] R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2, R_ERR = 2'd3;

  localparam b_chan_t BErr = '{resp: 2'b11};
  localparam r_chan_t RErr = '{data: {DataWidth{1'b0}}, resp: 2'b11};

  if ((DataWidth != 32 && DataWidth != 64) || $bits(w_chan_t) != DataWidth + DataWidth / 8) begin : gen_bad_cfg
    $error("axi_lite_xbar_conn: unsupported DataWidth or W channel layout");
  end

  logic [NoSlvPorts-1:0][2:0]         w_state_q, w_state_d;
  logic [NoSlvPorts-1:0][1:0]         r_state_q, r_state_d;
  logic [NoSlvPorts-1:0][MstIdxW-1:0] w_tgt_q, w_tgt_d, r_tgt_q, r_tgt_d;
  aw_chan_t [NoSlvPorts-1:0]          aw_q, aw_d;
  ar_chan_t [NoSlvPorts-1:0]          ar_q, ar_d;
  logic [NoMstPorts-1:0]              w_lock_q, w_lock_d, r_lock_q, r_lock_d;
  logic [NoMstPorts-1:0][SlvIdxW-1:0] w_owner_q, w_owner_d, r_owner_q, r_owner_d;
  logic [NoMstPorts-1:0][SlvIdxW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;

  logic [NoSlvPorts-1:0][MstIdxW:0]     w_dec, r_dec;
  logic [NoSlvPorts-1:0]                w_release, r_release;
  logic [NoMstPorts-1:0][NoSlvPorts-1:0] w_req_m, r_req_m;
  logic [NoMstPorts-1:0][SlvIdxW:0]     w_pick, r_pick;

  // Returns {decerr, target}; the first matching rule wins, then the default route.
  function automatic logic [MstIdxW:0] decode(input logic [AddrWidth-1:0] addr, input int unsigned slv);
    logic        hit, err;
    int unsigned tgt;
    hit = 1'b0;
    err = 1'b0;
    tgt = 0;
    for (int unsigned r = 0; r < NoAddrRules; r++) begin
      if (!hit && addr >= addr_map_i[r].start_addr && addr < addr_map_i[r].end_addr) begin
        hit = 1'b1;
        tgt = 32'(addr_map_i[r].idx);
      end
    end
    if (!hit) begin
      if (en_default_mst_port_i[slv]) tgt = 32'(default_mst_port_i[slv]);
      else err = 1'b1;
    end
    if (!err) begin
      if (tgt >= NoMstPorts) err = 1'b1;
      else if (!Connectivity[slv][tgt]) err = 1'b1;
    end
    return {err, err ? MstIdxW'(0) : MstIdxW'(tgt)};
  endfunction

  function automatic logic [SlvIdxW:0] rr_pick(input logic [NoSlvPorts-1:0] req, input logic [SlvIdxW-1:0] ptr);
    logic                found;
    logic [SlvIdxW-1:0]  idx;
    int unsigned         k;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NoSlvPorts; off++) begin
      k = 32'(ptr) + off;
      if (k >= NoSlvPorts) k = k - NoSlvPorts;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = SlvIdxW'(k);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [SlvIdxW-1:0] next_ptr(input logic [SlvIdxW-1:0] gnt);
    return (32'(gnt) + 1 == NoSlvPorts) ? '0 : gnt + 1'b1;
  endfunction

  always_comb begin
    w_dec = '0;
    r_dec = '0;
    for (int unsigned i = 0; i < NoSlvPorts; i++) begin
      w_dec[i] = decode(slv_ports_req_i[i].aw.addr, i);
      r_dec[i] = decode(slv_ports_req_i[i].ar.addr, i);
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    w_tgt_d   = w_tgt_q;
    r_tgt_d   = r_tgt_q;
    aw_d      = aw_q;
    ar_d      = ar_q;
    w_release = '0;
    r_release = '0;
    for (int unsigned i = 0; i < NoSlvPorts; i++) begin
      case (w_state_q[i])
        W_IDLE: if (slv_ports_req_i[i].aw_valid) begin
          aw_d[i]      = slv_ports_req_i[i].aw;
          w_tgt_d[i]   = w_dec[i][MstIdxW-1:0];
          w_state_d[i] = w_dec[i][MstIdxW] ? W_ERR_DATA : W_REQ;
        end
        W_REQ: if (w_lock_q[w_tgt_q[i]] && w_owner_q[w_tgt_q[i]] == SlvIdxW'(i)
                   && mst_ports_resp_i[w_tgt_q[i]].aw_ready) w_state_d[i] = W_DATA;
        W_DATA: if (slv_ports_req_i[i].w_valid && mst_ports_resp_i[w_tgt_q[i]].w_ready)
          w_state_d[i] = W_RESP;
        W_RESP: if (mst_ports_resp_i[w_tgt_q[i]].b_valid && slv_ports_req_i[i].b_ready) begin
          w_state_d[i] = W_IDLE;
          w_release[i] = 1'b1;
        end
        W_ERR_DATA: if (slv_ports_req_i[i].w_valid) w_state_d[i] = W_ERR_RESP;
        W_ERR_RESP: if (slv_ports_req_i[i].b_ready) w_state_d[i] = W_IDLE;
        default: w_state_d[i] = W_IDLE;
      endcase
      case (r_state_q[i])
        R_IDLE: if (slv_ports_req_i[i].ar_valid) begin
          ar_d[i]      = slv_ports_req_i[i].ar;
          r_tgt_d[i]   = r_dec[i][MstIdxW-1:0];
          r_state_d[i] = r_dec[i][MstIdxW] ? R_ERR : R_REQ;
        end
        R_REQ: if (r_lock_q[r_tgt_q[i]] && r_owner_q[r_tgt_q[i]] == SlvIdxW'(i)
                   && mst_ports_resp_i[r_tgt_q[i]].ar_ready) r_state_d[i] = R_RESP;
        R_RESP: if (mst_ports_resp_i[r_tgt_q[i]].r_valid && slv_ports_req_i[i].r_ready) begin
          r_state_d[i] = R_IDLE;
          r_release[i] = 1'b1;
        end
        default: if (slv_ports_req_i[i].r_ready) r_state_d[i] = R_IDLE;
      endcase
    end
  end

  always_comb begin
    w_req_m = '0;
    r_req_m = '0;
    w_pick  = '0;
    r_pick  = '0;
    for (int unsigned j = 0; j < NoMstPorts; j++) begin
      for (int unsigned i = 0; i < NoSlvPorts; i++) begin
        w_req_m[j][i] = (w_state_q[i] == W_REQ) && (w_tgt_q[i] == MstIdxW'(j));
        r_req_m[j][i] = (r_state_q[i] == R_REQ) && (r_tgt_q[i] == MstIdxW'(j));
      end
      w_pick[j] = rr_pick(w_req_m[j], w_ptr_q[j]);
      r_pick[j] = rr_pick(r_req_m[j], r_ptr_q[j]);
    end
  end

  // A lock released this cycle is only re-granted next cycle, from the registered state.
  always_comb begin
    w_lock_d  = w_lock_q;
    r_lock_d  = r_lock_q;
    w_owner_d = w_owner_q;
    r_owner_d = r_owner_q;
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    for (int unsigned j = 0; j < NoMstPorts; j++) begin
      if (w_lock_q[j]) begin
        if (w_release[w_owner_q[j]]) w_lock_d[j] = 1'b0;
      end else if (w_pick[j][SlvIdxW]) begin
        w_lock_d[j]  = 1'b1;
        w_owner_d[j] = w_pick[j][SlvIdxW-1:0];
        w_ptr_d[j]   = next_ptr(w_pick[j][SlvIdxW-1:0]);
      end
      if (r_lock_q[j]) begin
        if (r_release[r_owner_q[j]]) r_lock_d[j] = 1'b0;
      end else if (r_pick[j][SlvIdxW]) begin
        r_lock_d[j]  = 1'b1;
        r_owner_d[j] = r_pick[j][SlvIdxW-1:0];
        r_ptr_d[j]   = next_ptr(r_pick[j][SlvIdxW-1:0]);
      end
    end
  end

  always_comb begin
    slv_ports_resp_o = '0;
    mst_ports_req_o  = '0;
    for (int unsigned i = 0; i < NoSlvPorts; i++) begin
      slv_ports_resp_o[i].aw_ready = (w_state_q[i] == W_IDLE);
      slv_ports_resp_o[i].ar_ready = (r_state_q[i] == R_IDLE);
      if (w_state_q[i] == W_ERR_DATA) slv_ports_resp_o[i].w_ready = 1'b1;
      if (w_state_q[i] == W_ERR_RESP) begin
        slv_ports_resp_o[i].b_valid = 1'b1;
        slv_ports_resp_o[i].b       = BErr;
      end
      if (r_state_q[i] == R_ERR) begin
        slv_ports_resp_o[i].r_valid = 1'b1;
        slv_ports_resp_o[i].r       = RErr;
      end
    end
    for (int unsigned j = 0; j < NoMstPorts; j++) begin
      if (w_lock_q[j]) begin
        case (w_state_q[w_owner_q[j]])
          W_REQ: begin
            mst_ports_req_o[j].aw_valid = 1'b1;
            mst_ports_req_o[j].aw       = aw_q[w_owner_q[j]];
          end
          W_DATA: begin
            mst_ports_req_o[j].w_valid          = slv_ports_req_i[w_owner_q[j]].w_valid;
            mst_ports_req_o[j].w                = slv_ports_req_i[w_owner_q[j]].w;
            slv_ports_resp_o[w_owner_q[j]].w_ready = mst_ports_resp_i[j].w_ready;
          end
          W_RESP: begin
            mst_ports_req_o[j].b_ready          = slv_ports_req_i[w_owner_q[j]].b_ready;
            slv_ports_resp_o[w_owner_q[j]].b_valid = mst_ports_resp_i[j].b_valid;
            slv_ports_resp_o[w_owner_q[j]].b       = mst_ports_resp_i[j].b;
          end
          default: ;
        endcase
      end
      if (r_lock_q[j]) begin
        case (r_state_q[r_owner_q[j]])
          R_REQ: begin
            mst_ports_req_o[j].ar_valid = 1'b1;
            mst_ports_req_o[j].ar       = ar_q[r_owner_q[j]];
          end
          R_RESP: begin
            mst_ports_req_o[j].r_ready          = slv_ports_req_i[r_owner_q[j]].r_ready;
            slv_ports_resp_o[r_owner_q[j]].r_valid = mst_ports_resp_i[j].r_valid;
            slv_ports_resp_o[r_owner_q[j]].r       = mst_ports_resp_i[j].r;
          end
          default: ;
        endcase
      end
    end
    if (rst_i) begin
      slv_ports_resp_o = '0;
      mst_ports_req_o  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= '0;
      r_state_q <= '0;
      w_tgt_q   <= '0;
      r_tgt_q   <= '0;
      aw_q      <= '0;
      ar_q      <= '0;
      w_lock_q  <= '0;
      r_lock_q  <= '0;
      w_owner_q <= '0;
      r_owner_q <= '0;
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_tgt_q   <= w_tgt_d;
      r_tgt_q   <= r_tgt_d;
      aw_q      <= aw_d;
      ar_q      <= ar_d;
      w_lock_q  <= w_lock_d;
      r_lock_q  <= r_lock_d;
      w_owner_q <= w_owner_d;
      r_owner_q <= r_owner_d;
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_xbar_conn.sv
// Directed bench for axi_lite_xbar_conn: routing, arbitration order, DECERR paths and reset.
module tb_axi_lite_xbar_conn;
  import axi_lite_xbar_conn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_t  [1:0] slv_req, nc_slv_req;
  resp_t [1:0] slv_resp, nc_slv_resp;
  req_t  [1:0] mst_req, nc_mst_req;
  resp_t [1:0] mst_resp, nc_mst_resp;
  rule_t [1:0] addr_map;
  logic  [1:0] en_def, nc_en_def;
  logic  [1:0][0:0] def_port, nc_def_port;

  int n_checks = 0;
  int n_errors = 0;

  axi_lite_xbar_conn dut (
    .clk_i(clk), .rst_i(rst),
    .slv_ports_req_i(slv_req), .slv_ports_resp_o(slv_resp),
    .mst_ports_req_o(mst_req), .mst_ports_resp_i(mst_resp),
    .addr_map_i(addr_map), .en_default_mst_port_i(en_def), .default_mst_port_i(def_port)
  );

  // Second instance: slave 1 may not reach master 0.
  axi_lite_xbar_conn #(.Connectivity(4'b1011)) dut_nc (
    .clk_i(clk), .rst_i(rst),
    .slv_ports_req_i(nc_slv_req), .slv_ports_resp_o(nc_slv_resp),
    .mst_ports_req_o(nc_mst_req), .mst_ports_resp_i(nc_mst_resp),
    .addr_map_i(addr_map), .en_default_mst_port_i(nc_en_def), .default_mst_port_i(nc_def_port)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    slv_req     = '0;
    nc_slv_req  = '0;
    nc_mst_resp = '0;
    en_def      = '0;
    nc_en_def   = '0;
    def_port    = '0;
    nc_def_port = '0;
    addr_map[0] = '{idx: 32'd0, start_addr: 32'h0000, end_addr: 32'h1000};
    addr_map[1] = '{idx: 32'd1, start_addr: 32'h1000, end_addr: 32'h2000};
    for (int j = 0; j < 2; j++) begin
      mst_resp[j]          = '0;
      mst_resp[j].aw_ready = 1'b1;
      mst_resp[j].w_ready  = 1'b1;
      mst_resp[j].b_valid  = 1'b1;
      mst_resp[j].ar_ready = 1'b1;
      mst_resp[j].r_valid  = 1'b1;
      mst_resp[j].r.data   = 32'hDA7A_0000 + 32'(j);
    end

    // Reset state
    repeat (3) tick();
    check_val("rst_aw_ready", 64'(slv_resp[0].aw_ready), 64'd0);
    check_val("rst_ar_ready", 64'(slv_resp[1].ar_ready), 64'd0);
    check_val("rst_mst_quiet", 64'(|mst_req), 64'd0);
    rst = 1'b0;
    tick();
    check_val("post_rst_aw_ready", 64'(slv_resp[0].aw_ready), 64'd1);
    check_val("post_rst_ar_ready", 64'(slv_resp[1].ar_ready), 64'd1);

    // Write 0x1004 from slave 0 -> master 1
    slv_req[0].aw.addr = 32'h1004;
    slv_req[0].aw_valid = 1'b1;
    slv_req[0].w.data = 32'hA5;
    slv_req[0].w.strb = 4'hF;
    slv_req[0].w_valid = 1'b1;
    slv_req[0].b_ready = 1'b1;
    tick();
    check_val("wr_t1_aw_ready", 64'(slv_resp[0].aw_ready), 64'd0);
    check_val("wr_t1_mst_aw", 64'(mst_req[1].aw_valid), 64'd0);
    slv_req[0].aw_valid = 1'b0;
    tick();
    check_val("wr_t2_mst_aw", 64'(mst_req[1].aw_valid), 64'd1);
    check_val("wr_t2_mst_addr", 64'(mst_req[1].aw.addr), 64'h1004);
    check_val("wr_t2_mst0_aw", 64'(mst_req[0].aw_valid), 64'd0);
    tick();
    check_val("wr_w_valid", 64'(mst_req[1].w_valid), 64'd1);
    check_val("wr_w_data", 64'(mst_req[1].w.data), 64'hA5);
    check_val("wr_aw_dropped", 64'(mst_req[1].aw_valid), 64'd0);
    tick();
    check_val("wr_b_valid", 64'(slv_resp[0].b_valid), 64'd1);
    check_val("wr_b_resp", 64'(slv_resp[0].b.resp), 64'd0);
    slv_req[0].w_valid = 1'b0;
    tick();
    check_val("wr_done_idle", 64'(slv_resp[0].aw_ready), 64'd1);
    check_val("wr_done_b", 64'(slv_resp[0].b_valid), 64'd0);

    // Both slaves read 0x0010; prot tells the owner apart on master 0
    slv_req[0].ar.addr = 32'h10;
    slv_req[0].ar.prot = 3'b000;
    slv_req[0].ar_valid = 1'b1;
    slv_req[0].r_ready = 1'b1;
    slv_req[1].ar.addr = 32'h10;
    slv_req[1].ar.prot = 3'b010;
    slv_req[1].ar_valid = 1'b1;
    slv_req[1].r_ready = 1'b1;
    tick();
    check_val("rr_t1_ar", 64'(mst_req[0].ar_valid), 64'd0);
    slv_req[1].ar_valid = 1'b0;
    tick();
    check_val("rr_first_ar", 64'(mst_req[0].ar_valid), 64'd1);
    check_val("rr_first_owner", 64'(mst_req[0].ar.prot), 64'd0);
    tick();
    check_val("rr_s0_r_valid", 64'(slv_resp[0].r_valid), 64'd1);
    check_val("rr_s0_r_data", 64'(slv_resp[0].r.data), 64'hDA7A_0000);
    check_val("rr_s1_waiting", 64'(slv_resp[1].r_valid), 64'd0);
    tick();
    check_val("rr_release_gap", 64'(mst_req[0].ar_valid), 64'd0);
    tick();
    // slave 0 re-requested immediately; slave 1 must still win this grant
    check_val("rr_second_ar", 64'(mst_req[0].ar_valid), 64'd1);
    check_val("rr_second_owner", 64'(mst_req[0].ar.prot), 64'd2);
    slv_req[0].ar_valid = 1'b0;
    tick();
    check_val("rr_s1_r_valid", 64'(slv_resp[1].r_valid), 64'd1);
    check_val("rr_s0_held", 64'(slv_resp[0].r_valid), 64'd0);
    tick();
    tick();
    check_val("rr_third_owner", 64'(mst_req[0].ar.prot), 64'd0);
    check_val("rr_third_ar", 64'(mst_req[0].ar_valid), 64'd1);
    tick();
    check_val("rr_s0_second_r", 64'(slv_resp[0].r_valid), 64'd1);
    tick();
    check_val("rr_done", 64'(slv_resp[0].ar_ready), 64'd1);

    // Unmapped read, default disabled -> DECERR, no master activity
    slv_req[0].ar.addr = 32'h5000;
    slv_req[0].ar_valid = 1'b1;
    tick();
    check_val("decerr_r_valid", 64'(slv_resp[0].r_valid), 64'd1);
    check_val("decerr_r_resp", 64'(slv_resp[0].r.resp), 64'd3);
    check_val("decerr_r_data", 64'(slv_resp[0].r.data), 64'd0);
    check_val("decerr_no_mst", 64'({mst_req[0].ar_valid, mst_req[1].ar_valid}), 64'd0);
    slv_req[0].ar_valid = 1'b0;
    tick();
    check_val("decerr_r_done", 64'(slv_resp[0].r_valid), 64'd0);

    // End address is exclusive: 0x2000 falls through to the default port 1
    en_def[0] = 1'b1;
    def_port[0] = 1'b1;
    slv_req[0].ar.addr = 32'h2000;
    slv_req[0].ar_valid = 1'b1;
    tick();
    slv_req[0].ar_valid = 1'b0;
    tick();
    check_val("dflt_mst1_ar", 64'(mst_req[1].ar_valid), 64'd1);
    check_val("dflt_mst1_addr", 64'(mst_req[1].ar.addr), 64'h2000);
    check_val("dflt_mst0_idle", 64'(mst_req[0].ar_valid), 64'd0);
    tick();
    check_val("dflt_r_data", 64'(slv_resp[0].r.data), 64'hDA7A_0001);
    tick();
    en_def[0] = 1'b0;

    // Blocked connectivity on second instance: slave 1 write to 0x0
    nc_slv_req[1].aw.addr = 32'h0;
    nc_slv_req[1].aw_valid = 1'b1;
    nc_slv_req[1].w_valid = 1'b1;
    nc_slv_req[1].b_ready = 1'b1;
    tick();
    check_val("conn_w_absorb", 64'(nc_slv_resp[1].w_ready), 64'd1);
    check_val("conn_mst0_quiet", 64'({nc_mst_req[0].aw_valid, nc_mst_req[0].w_valid}), 64'd0);
    nc_slv_req[1].aw_valid = 1'b0;
    tick();
    nc_slv_req[1].w_valid = 1'b0;
    check_val("conn_b_valid", 64'(nc_slv_resp[1].b_valid), 64'd1);
    check_val("conn_b_resp", 64'(nc_slv_resp[1].b.resp), 64'd3);
    check_val("conn_w_ready_off", 64'(nc_slv_resp[1].w_ready), 64'd0);
    tick();
    check_val("conn_done", 64'(nc_slv_resp[1].b_valid), 64'd0);
    check_val("conn_mst0_never", 64'(|nc_mst_req), 64'd0);

    // Concurrent write and read from slave 0 to master 1
    slv_req[0].aw.addr = 32'h1008;
    slv_req[0].aw_valid = 1'b1;
    slv_req[0].w.data = 32'h77;
    slv_req[0].w_valid = 1'b1;
    slv_req[0].ar.addr = 32'h1010;
    slv_req[0].ar_valid = 1'b1;
    tick();
    slv_req[0].aw_valid = 1'b0;
    slv_req[0].ar_valid = 1'b0;
    tick();
    check_val("conc_aw_ar", 64'({mst_req[1].aw_valid, mst_req[1].ar_valid}), 64'd3);
    tick();
    check_val("conc_w_valid", 64'(mst_req[1].w_valid), 64'd1);
    check_val("conc_r_valid", 64'(slv_resp[0].r_valid), 64'd1);
    tick();
    check_val("conc_b_valid", 64'(slv_resp[0].b_valid), 64'd1);
    slv_req[0].w_valid = 1'b0;
    tick();
    check_val("conc_idle", 64'({slv_resp[0].aw_ready, slv_resp[0].ar_ready}), 64'd3);

    // Reset while in W_DATA
    slv_req[0].aw.addr = 32'h0004;
    slv_req[0].aw_valid = 1'b1;
    tick();
    slv_req[0].aw_valid = 1'b0;
    tick();
    tick();
    check_val("rstmid_in_wdata", 64'(slv_resp[0].w_ready), 64'd1);
    rst = 1'b1;
    tick();
    check_val("rstmid_slv_zero", 64'(|slv_resp), 64'd0);
    check_val("rstmid_mst_zero", 64'(|mst_req), 64'd0);
    rst = 1'b0;
    tick();
    check_val("rstmid_no_b", 64'(slv_resp[0].b_valid), 64'd0);
    check_val("rstmid_aw_ready", 64'(slv_resp[0].aw_ready), 64'd1);
    slv_req[0].aw.addr = 32'h0008;
    slv_req[0].aw_valid = 1'b1;
    slv_req[0].w.data = 32'h3C;
    slv_req[0].w_valid = 1'b1;
    tick();
    slv_req[0].aw_valid = 1'b0;
    tick();
    check_val("after_rst_aw", 64'(mst_req[0].aw_valid), 64'd1);
    check_val("after_rst_addr", 64'(mst_req[0].aw.addr), 64'h8);
    tick();
    check_val("after_rst_w_data", 64'(mst_req[0].w.data), 64'h3C);
    tick();
    check_val("after_rst_b", 64'(slv_resp[0].b_valid), 64'd1);
    slv_req[0].w_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
